ysyx_23060020_lsu: RTL and testbench
====================================

Name: ysyx_23060020_lsu

Overview:
Load/store unit sitting directly upstream of ysyx_23060020_mem, between EXU and WBU in the NPC core.
- Accepts one memory request per valid/ready handshake.
- Converts byte, half and word accesses into word-aligned mem port transactions. SB/SH use read-modify-write because the mem port writes whole words only.
- Returns sign- or zero-extended load data through a valid/ready response channel.

Parameters:
ERR_RDATA, 32'h0000_0000, value driven on resp_rdata whenever resp_err=1

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
req_valid  input  1  request valid from EXU
req_ready  output  1  LSU can accept a request
req_wen  input  1  1=store, 0=load
req_funct3  input  3  RISC-V funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU
req_addr  input  32  byte address
req_wdata  input  32  store data, right-aligned
resp_valid  output  1  response valid to WBU
resp_ready  input  1  WBU accepts response
resp_rdata  output  32  extended load data (0 for stores)
resp_err  output  1  illegal funct3 or misaligned access
mem_ren  output  1  to mem ren
mem_wen  output  1  to mem wen (only asserted together with mem_ren)
mem_add  output  32  word-aligned address {addr[31:2],2'b00}
mem_data  output  32  merged write word
mem_outdata  input  32  combinational read word from mem

Behaviour:
- Clock and reset: single clock clk; reset rst_n is asynchronous, active-low.
- Reset values: state=IDLE, req_ready=1, resp_valid=0, resp_err=0, resp_rdata=0, mem_ren=0, mem_wen=0, mem_add=0, mem_data=0.
- Request capture: on req_valid&&req_ready in IDLE, latch wen, funct3, addr and wdata. req_ready=1 only in IDLE.
- FSM states: IDLE, RD, WR, RESP.
- IDLE transitions on accept:
  - illegal: funct3 is 011/110/111, or a store with funct3 1xx → RESP with err=1.
  - LW/LB/LH/LBU/LHU → RD.
  - SW → WR.
  - SB/SH → RD.
- RD: mem_ren=1, mem_wen=0. Capture mem_outdata at the clock edge.
  - Load: → RESP.
  - SB/SH: → WR.
- WR: mem_ren=1, mem_wen=1 for exactly one cycle, then → RESP.
  - SW: mem_data=wdata.
  - SB: captured word with byte lane addr[1:0] replaced by wdata[7:0].
  - SH: captured word with half lane addr[1] replaced by wdata[15:0].
- RESP: resp_valid=1 and resp_rdata/resp_err held stable until resp_ready, then → IDLE. No new accept in the handshake cycle.
- Load extraction: byte lane selected by addr[1:0], half lane by addr[1].
  - B and H sign-extend; BU and HU zero-extend.
  - Stores return resp_rdata=0.
- mem_add, mem_data: driven from latched registers in RD/WR, 0 otherwise. mem_ren=mem_wen=0 in IDLE and RESP.
- Latency from accept cycle T:
  - load, SW: resp_valid at T+2.
  - SB/SH: resp_valid at T+3.
  - err: resp_valid at T+1.
- Reset mid-operation: FSM returns to IDLE immediately and mem_ren/mem_wen drop asynchronously. The transaction is dropped with no response. A store reset before WR performs no write.
- Back-pressure: resp_ready may stay low indefinitely. The LSU holds RESP, req_ready stays 0, and no mem access occurs.

Optional Feature:
Macro: YSYX_23060020_LSU_MISALIGN_EN
- Defined: misaligned H/HU/SH (addr[0]=1) and W/SW (addr[1:0]!=0) go IDLE→RESP with resp_err=1 and resp_rdata=ERR_RDATA. No mem access.
- Undefined: no alignment check.
  - H uses lane addr[1] (addr[0] ignored).
  - W ignores addr[1:0].
  - resp_err is set only for illegal funct3.

Test Plan:
- Mem word 0x8000_0000=0x8899_AABB. LB addr 0x8000_0001 → resp_rdata=0xFFFF_FFAA at T+2. LBU same address → 0x0000_00AA.
- Same word. LH addr 0x8000_0002 → 0xFFFF_8899. LHU → 0x0000_8899. LW addr 0x8000_0000 → 0x8899_AABB.
- SB wdata=0x0000_0011 addr 0x8000_0002 → single WR cycle with mem_data=0x8811_AABB, resp_valid at T+3. Following LW → 0x8811_AABB.
- SW 0xDEAD_BEEF to 0x8000_0004 with resp_ready held low 5 cycles → exactly one mem_wen cycle, resp_valid held 5+ cycles, req_ready=0 throughout.
- funct3=011 load → resp_err=1 at T+1, mem_ren never asserted. With the macro defined, LW addr 0x8000_0002 → resp_err=1, resp_rdata=ERR_RDATA, no mem access.
- Assert rst_n=0 during RD of an SH → mem_ren drops the same cycle, no mem_wen, no resp_valid, and req_ready=1 after release.

Source files
------------

// File: rtl/ysyx_23060020_lsu.sv
// Load/store unit between EXU and WBU. It turns byte, half and word accesses into word-aligned mem port transactions.
// Optional macro YSYX_23060020_LSU_MISALIGN_EN rejects misaligned H/HU/SH and W/SW accesses with resp_err.
module ysyx_23060020_lsu #(
    parameter logic [31:0] ERR_RDATA = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_wen,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic        mem_ren,
    output logic        mem_wen,
    output logic [31:0] mem_add,
    output logic [31:0] mem_data,
    input  logic [31:0] mem_outdata
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        WR   = 2'd2,
        RESP = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic        wen_q;
    logic [2:0]  funct3_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [31:0] word_q;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q, err_d;

    logic        illegal;
    logic        misalign;
    logic [31:0] load_value;
    logic [31:0] store_word;

    assign illegal = (req_funct3 == 3'b011) || (req_funct3 == 3'b110) ||
                     (req_funct3 == 3'b111) || (req_wen && req_funct3[2]);

`ifdef YSYX_23060020_LSU_MISALIGN_EN
    assign misalign = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
                      ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
`else
    assign misalign = 1'b0;
`endif

    // Load extraction from the live mem word, so the result is registered at the RD edge.
    always_comb begin
        logic [7:0]  byte_sel;
        logic [15:0] half_sel;
        byte_sel   = mem_outdata[7:0];
        half_sel   = addr_q[1] ? mem_outdata[31:16] : mem_outdata[15:0];
        load_value = mem_outdata;
        case (addr_q[1:0])
            2'b00:   byte_sel = mem_outdata[7:0];
            2'b01:   byte_sel = mem_outdata[15:8];
            2'b10:   byte_sel = mem_outdata[23:16];
            default: byte_sel = mem_outdata[31:24];
        endcase
        case (funct3_q)
            3'b000:  load_value = {{24{byte_sel[7]}}, byte_sel};
            3'b100:  load_value = {24'h0, byte_sel};
            3'b001:  load_value = {{16{half_sel[15]}}, half_sel};
            3'b101:  load_value = {16'h0, half_sel};
            default: load_value = mem_outdata;
        endcase
    end

    // Read-modify-write merge of the word captured during RD.
    always_comb begin
        store_word = wdata_q;
        case (funct3_q[1:0])
            2'b00: begin
                store_word = word_q;
                case (addr_q[1:0])
                    2'b00:   store_word[7:0]   = wdata_q[7:0];
                    2'b01:   store_word[15:8]  = wdata_q[7:0];
                    2'b10:   store_word[23:16] = wdata_q[7:0];
                    default: store_word[31:24] = wdata_q[7:0];
                endcase
            end
            2'b01: begin
                store_word = word_q;
                if (addr_q[1]) store_word[31:16] = wdata_q[15:0];
                else           store_word[15:0]  = wdata_q[15:0];
            end
            default: store_word = wdata_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            wen_q    <= 1'b0;
            funct3_q <= 3'b000;
            addr_q   <= 32'h0;
            wdata_q  <= 32'h0;
            word_q   <= 32'h0;
            rdata_q  <= 32'h0;
            err_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
            if (state_q == IDLE && req_valid) begin
                wen_q    <= req_wen;
                funct3_q <= req_funct3;
                addr_q   <= req_addr;
                wdata_q  <= req_wdata;
            end
            if (state_q == RD) begin
                word_q <= mem_outdata;
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        rdata_d    = rdata_q;
        err_d      = err_q;
        req_ready  = 1'b0;
        resp_valid = 1'b0;
        resp_rdata = 32'h0;
        resp_err   = 1'b0;
        mem_ren    = 1'b0;
        mem_wen    = 1'b0;
        mem_add    = 32'h0;
        mem_data   = 32'h0;
        case (state_q)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    rdata_d = 32'h0;
                    err_d   = 1'b0;
                    if (illegal || misalign) begin
                        state_d = RESP;
                        err_d   = 1'b1;
                        rdata_d = ERR_RDATA;
                    end else if (req_wen && req_funct3 == 3'b010) begin
                        state_d = WR;
                    end else begin
                        state_d = RD;
                    end
                end
            end
            RD: begin
                mem_ren = 1'b1;
                mem_add = {addr_q[31:2], 2'b00};
                if (wen_q) begin
                    state_d = WR;
                end else begin
                    state_d = RESP;
                    rdata_d = load_value;
                end
            end
            WR: begin
                mem_ren  = 1'b1;
                mem_wen  = 1'b1;
                mem_add  = {addr_q[31:2], 2'b00};
                mem_data = store_word;
                state_d  = RESP;
            end
            RESP: begin
                resp_valid = 1'b1;
                resp_rdata = rdata_q;
                resp_err   = err_q;
                if (resp_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_ysyx_23060020_lsu.sv
// Directed testbench for ysyx_23060020_lsu with a small word-addressed memory model.
module tb_ysyx_23060020_lsu;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_wen = 1'b0;
    logic [2:0]  req_funct3 = 3'b000;
    logic [31:0] req_addr = 32'h0;
    logic [31:0] req_wdata = 32'h0;
    logic        resp_valid;
    logic        resp_ready = 1'b0;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        mem_ren;
    logic        mem_wen;
    logic [31:0] mem_add;
    logic [31:0] mem_data;
    logic [31:0] mem_outdata;

    logic [31:0] memArr [0:7];
    int          wenCount = 0;
    int          renCount = 0;
    logic [31:0] lastWData = 32'h0;
    logic [31:0] lastWAddr = 32'h0;
    int          checkCount = 0;
    int          passCount = 0;

    ysyx_23060020_lsu dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_wen(req_wen),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_rdata(resp_rdata), .resp_err(resp_err),
        .mem_ren(mem_ren), .mem_wen(mem_wen), .mem_add(mem_add),
        .mem_data(mem_data), .mem_outdata(mem_outdata)
    );

    always #5 clk = ~clk;

    assign mem_outdata = memArr[mem_add[4:2]];

    // Memory model: writes land at the clock edge, and every enable cycle is counted.
    always @(posedge clk) begin
        if (mem_wen) begin
            wenCount  <= wenCount + 1;
            lastWData <= mem_data;
            lastWAddr <= mem_add;
            memArr[mem_add[4:2]] <= mem_data;
        end
        if (mem_ren) renCount <= renCount + 1;
    end

    task automatic do_req(input logic w, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] wd, input int hold, output int lat,
                          output logic [31:0] rd, output logic er, output logic heldOk);
        @(negedge clk);
        req_valid = 1'b1; req_wen = w; req_funct3 = f3; req_addr = a; req_wdata = wd;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        lat = 1;
        while (!resp_valid && lat < 10) begin
            @(negedge clk);
            lat++;
        end
        rd = resp_rdata; er = resp_err; heldOk = 1'b1;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            if (!resp_valid || req_ready || resp_rdata !== rd) heldOk = 1'b0;
        end
        resp_ready = 1'b1;
        @(posedge clk);
        #1 resp_ready = 1'b0;
    endtask

    task automatic test_reset();
        checkCount++; if (req_ready !== 1'b1) $display("[TB] FAIL reset_req_ready got %0b want 1", req_ready); else passCount++;
        checkCount++; if ({resp_valid, resp_err, mem_ren, mem_wen} !== 4'b0000) $display("[TB] FAIL reset_flags got %b want 0000", {resp_valid, resp_err, mem_ren, mem_wen}); else passCount++;
        checkCount++; if ({resp_rdata, mem_add, mem_data} !== 96'h0) $display("[TB] FAIL reset_data got %h want 0", {resp_rdata, mem_add, mem_data}); else passCount++;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_loads();
        logic [2:0]  f3s  [6] = '{3'b000, 3'b100, 3'b001, 3'b101, 3'b010, 3'b000};
        logic [31:0] adrs [6] = '{32'h8000_0001, 32'h8000_0001, 32'h8000_0002, 32'h8000_0002, 32'h8000_0000, 32'h8000_0003};
        logic [31:0] exps [6] = '{32'hFFFF_FFAA, 32'h0000_00AA, 32'hFFFF_8899, 32'h0000_8899, 32'h8899_AABB, 32'hFFFF_FF88};
        int lat; logic [31:0] rd; logic er, ok; int w0;
        w0 = wenCount;
        for (int i = 0; i < 6; i++) begin
            do_req(1'b0, f3s[i], adrs[i], 32'h0, 0, lat, rd, er, ok);
            checkCount++; if (rd !== exps[i] || er !== 1'b0) $display("[TB] FAIL load_%0d data got %h err %0b want %h err 0", i, rd, er, exps[i]); else passCount++;
            checkCount++; if (lat != 2) $display("[TB] FAIL load_%0d latency got %0d want 2", i, lat); else passCount++;
        end
        checkCount++; if (wenCount != w0) $display("[TB] FAIL load_no_write got %0d want 0", wenCount - w0); else passCount++;
    endtask

    task automatic test_store_sub();
        int lat; logic [31:0] rd; logic er, ok; int w0;
        w0 = wenCount;
        do_req(1'b1, 3'b000, 32'h8000_0002, 32'h0000_0011, 0, lat, rd, er, ok);
        checkCount++; if (lat != 3) $display("[TB] FAIL sb_latency got %0d want 3", lat); else passCount++;
        checkCount++; if (wenCount - w0 != 1) $display("[TB] FAIL sb_wen_cycles got %0d want 1", wenCount - w0); else passCount++;
        checkCount++; if (lastWData !== 32'h8811_AABB || lastWAddr !== 32'h8000_0000) $display("[TB] FAIL sb_write got %h@%h want 8811aabb@80000000", lastWData, lastWAddr); else passCount++;
        checkCount++; if (rd !== 32'h0 || er !== 1'b0) $display("[TB] FAIL sb_resp got %h err %0b want 0 err 0", rd, er); else passCount++;
        do_req(1'b0, 3'b010, 32'h8000_0000, 32'h0, 0, lat, rd, er, ok);
        checkCount++; if (rd !== 32'h8811_AABB) $display("[TB] FAIL lw_after_sb got %h want 8811aabb", rd); else passCount++;
        do_req(1'b1, 3'b001, 32'h8000_0000, 32'h1234_5678, 0, lat, rd, er, ok);
        checkCount++; if (lat != 3 || lastWData !== 32'h8811_5678) $display("[TB] FAIL sh_low got %h lat %0d want 88115678 lat 3", lastWData, lat); else passCount++;
        do_req(1'b1, 3'b001, 32'h8000_0002, 32'h0000_CAFE, 0, lat, rd, er, ok);
        checkCount++; if (lastWData !== 32'hCAFE_5678) $display("[TB] FAIL sh_high got %h want cafe5678", lastWData); else passCount++;
    endtask

    task automatic test_backpressure();
        int lat; logic [31:0] rd; logic er, ok; int w0, r0;
        w0 = wenCount; r0 = renCount;
        do_req(1'b1, 3'b010, 32'h8000_0004, 32'hDEAD_BEEF, 5, lat, rd, er, ok);
        checkCount++; if (lat != 2) $display("[TB] FAIL sw_latency got %0d want 2", lat); else passCount++;
        checkCount++; if (ok !== 1'b1) $display("[TB] FAIL sw_hold got %0b want 1", ok); else passCount++;
        checkCount++; if (wenCount - w0 != 1 || renCount - r0 != 1) $display("[TB] FAIL sw_mem_cycles got wen %0d ren %0d want 1 1", wenCount - w0, renCount - r0); else passCount++;
        checkCount++; if (memArr[1] !== 32'hDEAD_BEEF) $display("[TB] FAIL sw_data got %h want deadbeef", memArr[1]); else passCount++;
    endtask

    task automatic test_illegal();
        logic        ws  [3] = '{1'b0, 1'b1, 1'b0};
        logic [2:0]  f3s [3] = '{3'b011, 3'b100, 3'b111};
        int lat; logic [31:0] rd; logic er, ok; int r0;
        for (int i = 0; i < 3; i++) begin
            r0 = renCount;
            do_req(ws[i], f3s[i], 32'h8000_0000, 32'h5555_5555, 0, lat, rd, er, ok);
            checkCount++; if (er !== 1'b1 || rd !== 32'h0 || lat != 1) $display("[TB] FAIL illegal_%0d got err %0b data %h lat %0d want 1 0 1", i, er, rd, lat); else passCount++;
            checkCount++; if (renCount != r0) $display("[TB] FAIL illegal_%0d_ren got %0d want 0", i, renCount - r0); else passCount++;
        end
    endtask

    task automatic test_misalign();
        int lat; logic [31:0] rd; logic er, ok; int r0;
        r0 = renCount;
        do_req(1'b0, 3'b010, 32'h8000_0002, 32'h0, 0, lat, rd, er, ok);
`ifdef YSYX_23060020_LSU_MISALIGN_EN
        checkCount++; if (er !== 1'b1 || rd !== 32'h0 || lat != 1 || renCount != r0) $display("[TB] FAIL misalign_lw got err %0b data %h lat %0d ren %0d want 1 0 1 0", er, rd, lat, renCount - r0); else passCount++;
`else
        checkCount++; if (er !== 1'b0 || rd !== 32'hCAFE_5678 || lat != 2 || renCount - r0 != 1) $display("[TB] FAIL misalign_lw got err %0b data %h lat %0d want 0 cafe5678 2", er, rd, lat); else passCount++;
        do_req(1'b0, 3'b101, 32'h8000_0001, 32'h0, 0, lat, rd, er, ok);
        checkCount++; if (er !== 1'b0 || rd !== 32'h0000_5678) $display("[TB] FAIL misalign_lhu got err %0b data %h want 0 00005678", er, rd); else passCount++;
`endif
    endtask

    task automatic test_reset_midop();
        int w0;
        w0 = wenCount;
        @(negedge clk);
        req_valid = 1'b1; req_wen = 1'b1; req_funct3 = 3'b001; req_addr = 32'h8000_0004; req_wdata = 32'h0000_1111;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        checkCount++; if (mem_ren !== 1'b1) $display("[TB] FAIL midop_rd got ren %0b want 1", mem_ren); else passCount++;
        rst_n = 1'b0;
        #1;
        checkCount++; if (mem_ren !== 1'b0 || mem_wen !== 1'b0) $display("[TB] FAIL midop_drop got ren %0b wen %0b want 0 0", mem_ren, mem_wen); else passCount++;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        checkCount++; if (req_ready !== 1'b1 || resp_valid !== 1'b0) $display("[TB] FAIL midop_after got ready %0b valid %0b want 1 0", req_ready, resp_valid); else passCount++;
        checkCount++; if (wenCount != w0 || memArr[1] !== 32'hDEAD_BEEF) $display("[TB] FAIL midop_nowrite got wen %0d mem %h want 0 deadbeef", wenCount - w0, memArr[1]); else passCount++;
    endtask

    task automatic test_back_to_back();
        int lat; logic [31:0] rd; logic er, ok;
        do_req(1'b0, 3'b100, 32'h8000_0007, 32'h0, 0, lat, rd, er, ok);
        checkCount++; if (rd !== 32'h0000_00DE || lat != 2) $display("[TB] FAIL b2b_lbu got %h lat %0d want 000000de 2", rd, lat); else passCount++;
        do_req(1'b0, 3'b001, 32'h8000_0004, 32'h0, 0, lat, rd, er, ok);
        checkCount++; if (rd !== 32'hFFFF_BEEF || lat != 2) $display("[TB] FAIL b2b_lh got %h lat %0d want ffffbeef 2", rd, lat); else passCount++;
    endtask

    initial begin
        for (int i = 0; i < 8; i++) memArr[i] = 32'h0;
        memArr[0] = 32'h8899_AABB;
        #2;
        test_reset();
        test_loads();
        test_store_sub();
        test_backpressure();
        test_illegal();
        test_misalign();
        test_reset_midop();
        test_back_to_back();
        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
